// File: rtl/counter_ctrl.sv
// counter_ctrl: sequences one timed job on a shared up-counter.
// It clears the counter, gates its enable until count reaches the latched
// duration, then pulses done. Pause freezes counting. Abort cancels the job.
// Optional build macro: COUNTER_CTRL_AUTO_RELOAD_EN. When defined, DONE loops
// back to CLEAR and re-runs the job with the same latched duration.
module counter_ctrl #(
  parameter int unsigned NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_BITS-1:0] duration,
  input  logic                pause,
  input  logic                abort,
  input  logic [NUM_BITS-1:0] count,
  output logic                cnt_clear,
  output logic                cnt_enable,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [NUM_BITS-1:0] dur_q;
  logic [NUM_BITS-1:0] dur_nxt;
  logic                at_target;

  assign at_target = (count == dur_q);

  // State and latched duration. Reset is async active-low and forces IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      dur_q <= '0;
    end else begin
      state <= state_nxt;
      dur_q <= dur_nxt;
    end
  end

  // Next-state and output decode. The outputs come from the state, so reset
  // clears them immediately. cnt_enable also uses pause, abort and count
  // combinationally, so abort and the target match stop counting in the same cycle.
  always_comb begin
    state_nxt  = state;
    dur_nxt    = dur_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        // A start in IDLE wins over abort, which has no effect here.
        if (start) begin
          dur_nxt   = duration;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy      = 1'b1;
        cnt_clear = 1'b1;
        state_nxt = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        busy       = 1'b1;
        cnt_enable = !pause && !abort && !at_target;
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (at_target) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
          state_nxt = S_CLEAR;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl. It includes a behavioural counter that the
// DUT drives. Each job pushes its expected done cycle, final count and number
// of enabled cycles to a queue. That entry is popped and checked when done fires.
module tb_counter_ctrl;

  localparam int unsigned NB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NB-1:0] duration;
  logic          pause;
  logic          abort;
  logic [NB-1:0] count;
  logic          cnt_clear;
  logic          cnt_enable;
  logic          busy;
  logic          done;
  logic          cnt_rst_n;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int en_total = 0;
  int base  = 0;
  int en0   = 0;

  typedef struct {
    string tag;
    int    dcyc;
    int    cnt;
    int    en;
  } exp_t;

  exp_t exp_q[$];

  counter_ctrl #(.NUM_BITS(NB)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .duration   (duration),
    .pause      (pause),
    .abort      (abort),
    .count      (count),
    .cnt_clear  (cnt_clear),
    .cnt_enable (cnt_enable),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Shared counter model. It is reset only at time zero and never by the DUT's reset.
  always @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n)      count <= 8'h00;
    else if (cnt_clear)  count <= '0;
    else if (cnt_enable) count <= count + 8'd1;
  end

  // Free-running edge count and running total of enabled cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cnt_enable) en_total <= en_total + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge (optionally with abort). Afterwards the bench is in cycle 1.
  task automatic start_job(input int d, input logic with_abort, input string tag, input int dcyc);
    exp_t e;
    duration = NB'(d);
    start    = 1'b1;
    abort    = with_abort;
    step();
    start = 1'b0;
    abort = 1'b0;
    base  = cyc - 1;
    en0   = en_total;
    e.tag = tag; e.dcyc = dcyc; e.cnt = d; e.en = d;
    exp_q.push_back(e);
  endtask

  // Wait for done, bounded by budget. Then pop the expected entry and compare.
  task automatic check_job(input int budget);
    exp_t e;
    int   dc;
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      chk("exclusive", int'(cnt_clear & cnt_enable), 0);
      if (done) begin
        dc = cyc - base;
        break;
      end
    end
    if (exp_q.size() == 0) begin
      chk("queue_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "_done_cycle"}, dc, e.dcyc);
      chk({e.tag, "_count"}, int'(count), e.cnt);
      chk({e.tag, "_en_cycles"}, en_total - en0, e.en);
    end
  endtask

  initial begin
    bit seen;
    reset     = 1'b0;
    cnt_rst_n = 1'b0;
    start     = 1'b0;
    duration  = '0;
    pause     = 1'b0;
    abort     = 1'b0;
    repeat (5) step();
    chk("reset_outputs", int'({cnt_clear, cnt_enable, busy, done}), 0);
    reset     = 1'b1;
    cnt_rst_n = 1'b1;
    step();
    chk("idle_outputs", int'({cnt_clear, cnt_enable, busy, done}), 0);

`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
    // Auto reload with D=4: done in cycles 7, 14 and 21, then abort in cycle 22.
    begin
      exp_t e;
      start_job(4, 1'b0, "reload1", 7);
      check_job(20);
      e.tag = "reload2"; e.dcyc = 14; e.cnt = 4; e.en = 8;  exp_q.push_back(e);
      check_job(20);
      e.tag = "reload3"; e.dcyc = 21; e.cnt = 4; e.en = 12; exp_q.push_back(e);
      check_job(20);
      step();
      chk("reload_busy_c22", int'(busy), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("reload_abort_busy", int'(busy), 0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (done) seen = 1;
      end
      chk("reload_no_done", int'(seen), 0);
    end
`else
    // Basic job with D=10: clear in cycle 1, ten enabled cycles, done in cycle 13.
    start_job(10, 1'b0, "basic", 13);
    chk("basic_clear_c1", int'({cnt_clear, cnt_enable, busy}), 3'b101);
    step();
    chk("basic_run_c2", int'({cnt_clear, cnt_enable, count}), {2'b01, 8'd0});
    check_job(30);
    step();
    chk("basic_idle_c14", int'(busy), 0);

    // Pause in cycles 5..11 with D=20: count holds at 3 and done moves to cycle 30.
    start_job(20, 1'b0, "pause", 30);
    repeat (4) step();
    pause = 1'b1;
    #1;
    chk("pause_enable_low", int'(cnt_enable), 0);
    chk("pause_count_c5", int'(count), 3);
    repeat (6) step();
    chk("pause_count_c11", int'(count), 3);
    step();
    pause = 1'b0;
    chk("pause_count_c12", int'(count), 3);
    check_job(60);
    step();

    // Abort in cycle 15 with D=50: enable drops at once, IDLE in cycle 16, count stays 13.
    duration = 8'd50;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (14) step();
    abort = 1'b1;
    #1;
    chk("abort_enable_c15", int'(cnt_enable), 0);
    step();
    abort = 1'b0;
    chk("abort_busy_c16", int'(busy), 0);
    chk("abort_count", int'(count), 13);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) seen = 1;
    end
    chk("abort_no_done", int'(seen), 0);
    chk("abort_count_kept", int'(count), 13);

    // Edge durations.
    start_job(0, 1'b0, "dur0", 3);
    check_job(10);
    step();
    start_job(255, 1'b0, "dur255", 258);
    check_job(300);
    step();

    // A start while busy is ignored, and later duration changes do not matter.
    start_job(10, 1'b0, "busy_start", 13);
    repeat (3) step();
    duration = 8'd3;
    start    = 1'b1;
    step();
    start = 1'b0;
    check_job(30);
    step();
    chk("busy_start_idle", int'(busy), 0);

    // Start together with abort in IDLE: the job still starts.
    start_job(5, 1'b1, "start_abort", 8);
    check_job(20);
    step();

    // Reset in cycle 10 of a D=30 job: outputs clear at once and the counter keeps its value.
    start_job(30, 1'b0, "dummy", 0);
    void'(exp_q.pop_back());
    repeat (9) step();
    reset = 1'b0;
    #1;
    chk("reset_run_outputs", int'({cnt_clear, cnt_enable, busy, done}), 0);
    step();
    chk("reset_count_kept", int'(count), 8);
    reset = 1'b1;
    step();
    start_job(2, 1'b0, "after_reset", 5);
    check_job(20);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencer for the shared `NUM_BITS` up-counter. It accepts a timed job (start + duration), clears the counter, gates its enable until the count reaches the requested duration, then reports completion. It supports pause and abort. It sits between job-issuing logic and the counter, and owns the counter's `reset`/`enable` inputs exclusively.

## Interface
Parameters:
- `NUM_BITS`, 8, width of the counter and of `duration`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; low forces IDLE immediately.
- `start`  in  1  job request; sampled only in IDLE.
- `duration`  in  NUM_BITS  enabled-cycle count for the job; latched when `start` is accepted.
- `pause`  in  1  level; freezes counting while high in RUN.
- `abort`  in  1  cancels the active job.
- `count`  in  NUM_BITS  current counter value.
- `cnt_clear`  out  1  drives counter `reset`; counter reads 0 the cycle after.
- `cnt_enable`  out  1  drives counter `enable`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, CLEAR, RUN, DONE. A registered state plus `dur_q[NUM_BITS-1:0]`.
- IDLE:
  - `start`=1 → latch `dur_q`←`duration`, go to CLEAR.
  - `abort` is ignored in IDLE. If `start` and `abort` are both high, `start` is accepted.
- CLEAR: `cnt_clear`=1 for exactly one cycle, then go to RUN.
- RUN:
  - `cnt_enable` = `!pause && !abort && (count != dur_q)`, decoded combinationally.
  - `count == dur_q` → go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `abort`=1 in CLEAR, RUN or DONE → go to IDLE next cycle. No `done` pulse follows. `cnt_enable` drops in the same cycle. The counter keeps its value.
- `start` while busy is ignored. `duration` changes after acceptance have no effect.
- `duration`=0: CLEAR → RUN (count=0 matches) → DONE. `cnt_enable` is never asserted.
- `duration`=2^NUM_BITS−1: counts to all-ones without wrap. This is legal.
- Counter wrap is never exercised, because enable stops at `dur_q`.
- `cnt_clear` and `cnt_enable` are never high in the same cycle.
- Reset mid-job: the FSM goes to IDLE asynchronously and all outputs go low. The counter is not cleared by this block; the next job clears it.

## Timing
- Reset values: `cnt_clear`=0, `cnt_enable`=0, `busy`=0, `done`=0, state=IDLE, `dur_q`=0.
- Cycle numbering, with `start` accepted at edge 0 and no pause:
  - CLEAR in cycle 1.
  - RUN from cycle 2, with `count`=0.
  - `cnt_enable` high for cycles 2..D+1.
  - `count`=D in cycle D+2.
  - `done` in cycle D+3.
  - IDLE in cycle D+4.
- Each pause cycle inside RUN adds exactly one cycle to the job.
- `busy` is high from cycle 1 through cycle D+3 inclusive.
- Next `start` is accepted no earlier than cycle D+4.

## Configuration
- Macro: `COUNTER_CTRL_AUTO_RELOAD_EN`.
- Defined: DONE goes to CLEAR instead of IDLE, re-running with the same `dur_q`.
  - `done` pulses every D+3 cycles.
  - `busy` stays high until `abort` or reset.
- Undefined: single-shot; DONE goes to IDLE, as described above.

## Test plan
- Basic job: reset low for 5 cycles, release, `start` with `duration`=10 → `cnt_clear` 1 cycle; `cnt_enable` for exactly 10 cycles; `count` ends at 10; `done` pulses once in cycle 13.
- Pause: `duration`=20, `pause` high for 7 cycles mid-RUN → `count` holds during the pause; `done` in cycle 30; total enable cycles = 20.
- Abort: `duration`=50, `abort` in cycle 15 → `cnt_enable` low in cycle 15; IDLE in cycle 16; no `done`; `count`=13 retained.
- Edge durations:
  - `duration`=0 → no enable cycles; `done` in cycle 3.
  - `duration`=255 → `count`=255, no wrap, `done` in cycle 258.
- Collisions: `start` while busy → ignored, `dur_q` unchanged. `start`+`abort` in IDLE → job starts. Reset asserted in RUN → all outputs 0 immediately.
- With `COUNTER_CTRL_AUTO_RELOAD_EN`, `duration`=4 → `done` at cycles 7, 14, 21; `abort` stops the repetition.
